layer_sequencer: RTL and testbench

- Time-multiplexes one Neuron datapath across all neurons of a fully connected layer.
- On start, latches the layer input vector, then evaluates neurons 0..NUM_NEURONS-1 in order. For each neuron it fetches the weight row and bias from a synchronous parameter ROM, drives the Neuron, and captures its 8-bit output into a packed result buffer.
- Sits between the network top-level controller and the shared Neuron instance and its parameter memory.

---
 rtl/layer_sequencer_pkg.sv | 21 ++
 rtl/layer_sequencer_if.sv | 33 +++
 rtl/neuron_slot_buffer.sv | 34 +++
 rtl/layer_sequencer.sv | 117 +++++++++++
 tb/tb_layer_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/layer_sequencer_pkg.sv
// Shared types and constants for the layer sequencer and its slot buffer.
// Holds the state encoding, the byte width and the default input count.
package layer_sequencer_pkg;

    localparam int BYTE_W     = 8;
    localparam int NUM_IN_DEF = 62;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_LOAD = 3'd2,
        ST_EVAL = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Width of a down-counter that must hold max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Bundle of controller, parameter-ROM and Neuron signals around one layer sequencer.
// The slave modport is the sequencer side; master is the surrounding environment.
interface layer_sequencer_if
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_IN      = NUM_IN_DEF,
    parameter int NUM_NEURONS = 30,
    parameter int ADDR_W      = 5
);
    logic                          start;
    logic [NUM_IN*BYTE_W-1:0]      in_vec;
    logic                          busy;
    logic                          done;
    logic [NUM_NEURONS*BYTE_W-1:0] out_vec;
    logic                          rom_rd_en;
    logic [ADDR_W-1:0]             rom_addr;
    logic [NUM_IN*BYTE_W-1:0]      rom_weight;
    logic [BYTE_W-1:0]             rom_bias;
    logic [NUM_IN*BYTE_W-1:0]      neu_in;
    logic [NUM_IN*BYTE_W-1:0]      neu_weight;
    logic [BYTE_W-1:0]             neu_bias;
    logic [BYTE_W-1:0]             neu_out;

    modport slave (
        input  start, in_vec, rom_weight, rom_bias, neu_out,
        output busy, done, out_vec, rom_rd_en, rom_addr, neu_in, neu_weight, neu_bias
    );

    modport master (
        output start, in_vec, rom_weight, rom_bias, neu_out,
        input  busy, done, out_vec, rom_rd_en, rom_addr, neu_in, neu_weight, neu_bias
    );
endinterface

// File: rtl/neuron_slot_buffer.sv
// Per-neuron byte register file with async clear and packed read-out.
// The packed output doubles as the next layer's input vector.
module neuron_slot_buffer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int ADDR_W      = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_wr_en,
    input  logic [ADDR_W-1:0]             i_wr_idx,
    input  logic [BYTE_W-1:0]             i_wr_data,
    output logic [NUM_NEURONS*BYTE_W-1:0] o_rd_vec
);

    logic [NUM_NEURONS*BYTE_W-1:0] r_slots;

    // Slot write port; indices beyond the last neuron match no slot and are dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slots <= '0;
        end else begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                if (i_wr_en && (i_wr_idx == ADDR_W'(n))) begin
                    r_slots[n*BYTE_W +: BYTE_W] <= i_wr_data;
                end
            end
        end
    end

    assign o_rd_vec = r_slots;

endmodule

// File: rtl/layer_sequencer.sv
// Steps one shared Neuron through every neuron of a fully connected layer,
// fetching each weight row from a synchronous ROM and collecting the outputs.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_IN      = NUM_IN_DEF,
    parameter int NUM_NEURONS = 30,
    parameter int ADDR_W      = 5,
    parameter int SETTLE      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    layer_sequencer_if.slave  bus
);

    localparam int                CNT_W    = cnt_width(SETTLE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    state_e                   r_state;
    logic [ADDR_W-1:0]        r_idx;
    logic [CNT_W-1:0]         r_settle;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_rom_rd_en;
    logic [ADDR_W-1:0]        r_rom_addr;
    logic [NUM_IN*BYTE_W-1:0] r_neu_in;
    logic [NUM_IN*BYTE_W-1:0] r_neu_weight;
    logic [BYTE_W-1:0]        r_neu_bias;
    logic                     w_capture;

    // Last settle cycle of a neuron: its output is written into the slot buffer at this edge.
    assign w_capture = (r_state == ST_EVAL) && (r_settle == CNT_W'(1));

    // Sequencer FSM; every output is set on the transition into the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_settle     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rom_rd_en  <= 1'b0;
            r_rom_addr   <= '0;
            r_neu_in     <= '0;
            r_neu_weight <= '0;
            r_neu_bias   <= '0;
        end else begin
            r_rom_rd_en <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_neu_in    <= bus.in_vec;
                        r_idx       <= '0;
                        r_rom_addr  <= '0;
                        r_rom_rd_en <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_neu_weight <= bus.rom_weight;
                    r_neu_bias   <= bus.rom_bias;
                    r_settle     <= CNT_W'(SETTLE);
                    r_state      <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (w_capture) begin
                        if (r_idx == LAST_IDX) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx       <= r_idx + ADDR_W'(1);
                            r_rom_addr  <= r_idx + ADDR_W'(1);
                            r_rom_rd_en <= 1'b1;
                            r_state     <= ST_READ;
                        end
                    end else begin
                        r_settle <= r_settle - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    neuron_slot_buffer #(
        .NUM_NEURONS (NUM_NEURONS),
        .ADDR_W      (ADDR_W)
    ) u_slots (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (w_capture),
        .i_wr_idx  (r_idx),
        .i_wr_data (bus.neu_out),
        .o_rd_vec  (bus.out_vec)
    );

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.rom_rd_en  = r_rom_rd_en;
    assign bus.rom_addr   = r_rom_addr;
    assign bus.neu_in     = r_neu_in;
    assign bus.neu_weight = r_neu_weight;
    assign bus.neu_bias   = r_neu_bias;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench: two sequencers (4 neurons/settle 1 and 2 neurons/settle 3)
// with a ROM model and a Neuron model that outputs junk until inputs have settled.
module tb_layer_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   mode_a = 0;
    int   mode_b = 0;
    int   age_a  = 0;
    int   age_b  = 0;
    int   busy_a = 0, rd_a = 0, done_a = 0, rd_b = 0, done_b = 0;
    logic [31:0] alog_a = 32'd0;
    logic [31:0] alog_b = 32'd0;
    logic [31:0] pw_a, pi_a, pw_b, pi_b;
    logic [7:0]  pb_a, pb_b;

    typedef struct packed { logic [31:0] vec; logic [31:0] start; } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    layer_sequencer_if #(.NUM_IN(4), .NUM_NEURONS(4), .ADDR_W(2)) if_a ();
    layer_sequencer_if #(.NUM_IN(4), .NUM_NEURONS(2), .ADDR_W(1)) if_b ();

    layer_sequencer #(.NUM_IN(4), .NUM_NEURONS(4), .ADDR_W(2), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    layer_sequencer #(.NUM_IN(4), .NUM_NEURONS(2), .ADDR_W(1), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_w0(input int mode, input int addr);
        case (mode)
            2: return 8'h7F;
            3: case (addr)
                   0: return 8'h7F;
                   1: return 8'h40;
                   2: return 8'h20;
                   default: return 8'h08;
               endcase
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rom_b(input int mode);
        case (mode)
            0: return 8'h7F;
            1: return 8'h85;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int sm(input logic [7:0] x);
        return x[7] ? -int'(x[6:0]) : int'(x[6:0]);
    endfunction

    // Neuron reference: sign-magnitude MAC, bias scaled by 127, ReLU, >>9, saturate.
    function automatic logic [7:0] nmodel(input logic [31:0] iv, input logic [31:0] wv,
                                          input logic [7:0] b);
        int acc;
        acc = sm(b) * 127;
        for (int k = 0; k < 4; k++) acc += sm(iv[k*8 +: 8]) * sm(wv[k*8 +: 8]);
        if (acc < 0) acc = 0;
        acc = acc >>> 9;
        if (acc > 127) acc = 127;
        return 8'(acc);
    endfunction

    always @(posedge clk) begin
        if (if_a.rom_rd_en) begin
            if_a.rom_weight <= {24'h0, rom_w0(mode_a, int'(if_a.rom_addr))};
            if_a.rom_bias   <= rom_b(mode_a);
        end
        if (if_b.rom_rd_en) begin
            if_b.rom_weight <= {24'h0, rom_w0(mode_b, int'(if_b.rom_addr))};
            if_b.rom_bias   <= rom_b(mode_b);
        end
    end

    always @(negedge clk) begin
        pw_a <= if_a.neu_weight; pi_a <= if_a.neu_in; pb_a <= if_a.neu_bias;
        pw_b <= if_b.neu_weight; pi_b <= if_b.neu_in; pb_b <= if_b.neu_bias;
        if (if_a.neu_weight != pw_a || if_a.neu_in != pi_a || if_a.neu_bias != pb_a) age_a <= 0;
        else if (age_a < 100) age_a <= age_a + 1;
        if (if_b.neu_weight != pw_b || if_b.neu_in != pi_b || if_b.neu_bias != pb_b) age_b <= 0;
        else if (age_b < 100) age_b <= age_b + 1;
    end

    always_comb begin
        if_a.neu_out = (age_a >= 0) ? nmodel(if_a.neu_in, if_a.neu_weight, if_a.neu_bias) : 8'hEE;
        if_b.neu_out = (age_b >= 2) ? nmodel(if_b.neu_in, if_b.neu_weight, if_b.neu_bias) : 8'hEE;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            busy_a = 0; rd_a = 0; alog_a = 32'd0;
        end else begin
            if (if_a.busy) busy_a++;
            if (if_a.rom_rd_en) begin rd_a++; alog_a = (alog_a << 2) | 32'(if_a.rom_addr); end
            if (if_a.done) begin
                done_a++;
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done_a actual=1 expected=0");
                end else begin
                    e = q_a.pop_front();
                    check("out_vec_a", if_a.out_vec, e.vec);
                    check("latency_a", 32'(cyc) - e.start, 32'd13);
                    check("busy_cycles_a", 32'(busy_a), 32'd12);
                    check("busy_at_done_a", 32'(if_a.busy), 32'd0);
                    check("rd_count_a", 32'(rd_a), 32'd4);
                    check("addr_seq_a", alog_a, 32'h1B);
                end
                busy_a = 0; rd_a = 0; alog_a = 32'd0;
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            rd_b = 0; alog_b = 32'd0;
        end else begin
            if (if_b.rom_rd_en) begin rd_b++; alog_b = (alog_b << 1) | 32'(if_b.rom_addr); end
            if (if_b.done) begin
                done_b++;
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done_b actual=1 expected=0");
                end else begin
                    e = q_b.pop_front();
                    check("out_vec_b", {16'h0, if_b.out_vec}, e.vec);
                    check("latency_b", 32'(cyc) - e.start, 32'd11);
                    check("rd_count_b", 32'(rd_b), 32'd2);
                    check("addr_seq_b", alog_b, 32'h1);
                end
                rd_b = 0; alog_b = 32'd0;
            end
        end
    end

    task automatic start_a(input int mode, input logic [31:0] vec, input logic [31:0] exp,
                           input bit push);
        @(negedge clk);
        mode_a = mode; if_a.in_vec = vec; if_a.start = 1'b1;
        if (push) q_a.push_back({exp, 32'(cyc)});
        @(negedge clk);
        if_a.start = 1'b0;
    endtask

    task automatic wait_done(input bit sel_b);
        int n;
        n = 0;
        while (!(sel_b ? if_b.done : if_a.done) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=none expected=done");
        end
    endtask

    initial begin
        if_a.start = 1'b0; if_a.in_vec = 32'h0;
        if_b.start = 1'b0; if_b.in_vec = 32'h0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", {31'h0, if_a.busy}, 32'd0);
        check("rst_done", {31'h0, if_a.done}, 32'd0);
        check("rst_rd_en", {31'h0, if_a.rom_rd_en}, 32'd0);
        check("rst_addr", {30'h0, if_a.rom_addr}, 32'd0);
        check("rst_out_vec", if_a.out_vec, 32'd0);
        check("rst_neu", if_a.neu_in | if_a.neu_weight | {24'h0, if_a.neu_bias}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_a(0, 32'h0000_0000, 32'h1F1F_1F1F, 1'b1); wait_done(1'b0);
        start_a(1, 32'h7F7F_7F7F, 32'h0000_0000, 1'b1); wait_done(1'b0);
        start_a(2, 32'h0000_007F, 32'h1F1F_1F1F, 1'b1); wait_done(1'b0);

        // Distinct rows; stray starts in cycle 5 and the DONE cycle, in_vec changed in cycle 2.
        start_a(3, 32'h0000_007F, 32'h0107_0F1F, 1'b1);
        @(negedge clk); if_a.in_vec = 32'h0;
        repeat (3) @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk); if_a.start = 1'b0;
        wait_done(1'b0);
        if_a.start = 1'b1;
        @(negedge clk); if_a.start = 1'b0;
        check("start_in_done_ignored", {31'h0, if_a.busy}, 32'd0);
        repeat (3) @(negedge clk);

        // Abort mid-run with an asynchronous reset in cycle 6.
        start_a(0, 32'h0000_0000, 32'h0, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, if_a.busy}, 32'd0);
        check("abort_done", {31'h0, if_a.done}, 32'd0);
        check("abort_out_vec", if_a.out_vec, 32'd0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        start_a(3, 32'h0000_007F, 32'h0107_0F1F, 1'b1); wait_done(1'b0);

        @(negedge clk);
        mode_b = 3; if_b.in_vec = 32'h0000_007F; if_b.start = 1'b1;
        q_b.push_back({32'h0000_0F1F, 32'(cyc)});
        @(negedge clk); if_b.start = 1'b0;
        wait_done(1'b1);

        repeat (4) @(negedge clk);
        check("done_count_a", 32'(done_a), 32'd5);
        check("done_count_b", 32'(done_b), 32'd1);
        check("pending_a", 32'(q_a.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
